// File: rtl/id_tokenizer.sv
// Splits a valid-qualified byte stream at delimiters and checks each token against letter+ digit{MIN_DIGITS,}.
// Latency 1 cycle from accepted character to all outputs; no backpressure, idle cycles (in_valid=0) hold state.
module id_tokenizer #(
    parameter int MAX_LEN    = 16,
    parameter int MIN_DIGITS = 1,
    parameter int ALLOW_US   = 1,
    parameter int CNT_W      = 8,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       char,
    output logic             match,
    output logic             tok_done,
    output logic             tok_ok,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] ok_count
);

    typedef enum logic [1:0] {IDLE, ALPHA, DIGIT, ERR} state_t;

    state_t           state, nstate;
    logic [LEN_W-1:0] len, dcnt, nlen, ndcnt;
    logic             is_letter, is_digit, is_delim;
    logic             len_full, tok_end, tok_good;

    always_comb begin
        is_letter = (char >= 8'h41 && char <= 8'h5A) ||
                    (char >= 8'h61 && char <= 8'h7A) ||
                    (ALLOW_US != 0 && char == 8'h5F);
        is_digit  = (char >= 8'h30 && char <= 8'h39);
        is_delim  = !(is_letter || is_digit);
        len_full  = (len == LEN_W'(MAX_LEN));
        tok_end   = is_delim && (state != IDLE);
        tok_good  = (state == DIGIT) && (dcnt >= LEN_W'(MIN_DIGITS));

        nstate = state;
        nlen   = len;
        ndcnt  = dcnt;
        if (is_delim) begin
            nstate = IDLE;
            nlen   = '0;
            ndcnt  = '0;
        end else begin
            nlen = len_full ? len : len + 1'b1;
            // A character beyond MAX_LEN poisons the token regardless of class.
            if (len_full) begin
                nstate = ERR;
            end else begin
                case (state)
                    IDLE:  nstate = is_letter ? ALPHA : ERR;
                    ALPHA: begin
                        if (is_digit) begin
                            nstate = DIGIT;
                            ndcnt  = LEN_W'(1);
                        end
                    end
                    DIGIT: begin
                        if (is_digit) begin
                            ndcnt = (dcnt == LEN_W'(MAX_LEN)) ? dcnt : dcnt + 1'b1;
                        end else begin
                            nstate = ERR;
                        end
                    end
                    ERR:   nstate = ERR;
                    default: nstate = ERR;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            dcnt     <= '0;
            match    <= 1'b0;
            tok_done <= 1'b0;
            tok_ok   <= 1'b0;
            tok_len  <= '0;
            ok_count <= '0;
        end else begin
            tok_done <= 1'b0;
            if (in_valid) begin
                state <= nstate;
                len   <= nlen;
                dcnt  <= ndcnt;
                match <= (nstate == DIGIT) && (ndcnt >= LEN_W'(MIN_DIGITS));
                if (tok_end) begin
                    tok_done <= 1'b1;
                    tok_ok   <= tok_good;
                    tok_len  <= len;
                    if (tok_good && ok_count != {CNT_W{1'b1}}) begin
                        ok_count <= ok_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule
